// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: FSM states, round count, Rcon and S-box tables, GF(2^8) helpers.
package aes128_pkg;

    localparam int AES_NR  = 10;
    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_fsm_e;

    // Rcon bytes for rounds 1..10, round 1 in the top byte.
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [3:0] rnd_m1;
        logic [6:0] idx;
        if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
            rnd_m1 = rnd - 4'd1;
            idx    = 7'd79 - {rnd_m1, 3'b000};
            return RCON_TABLE[idx -: 8];
        end else begin
            return 8'h00;
        end
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_round_core.sv
// Combinational AES-128 round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey,
// together with the matching KeyExpansion step. Byte 0 sits at bit 127.
module aes128_round_core
    import aes128_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rkey_i,
    input  logic [3:0]         round_i,
    input  logic               last_i,
    output logic [BLOCK_W-1:0] next_state_o,
    output logic [BLOCK_W-1:0] next_rkey_o
);

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] r;
        r = 128'h0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(b[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Byte (row + 4*col) is column-major; row r rotates left by r columns.
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(rw+4*c) -: 8] = b[127-8*(rw+4*((c+rw)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] mix_col(input logic [WORD_W-1:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_col(b[127-32*c -: 32]);
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] key_expansion_round(input logic [3:0]         rnd,
                                                               input logic [BLOCK_W-1:0] k);
        logic [WORD_W-1:0] w0, w1, w2, w3, rot, tmp, n0, n1, n2, n3;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(rnd), 24'h000000};
        n0  = w0 ^ tmp;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [BLOCK_W-1:0] rkey_next_s;
    logic [BLOCK_W-1:0] shifted_s;
    logic [BLOCK_W-1:0] mixed_s;

    assign rkey_next_s  = key_expansion_round(round_i, rkey_i);
    assign shifted_s    = shift_rows(sub_bytes(state_i));
    assign mixed_s      = last_i ? shifted_s : mix_columns(shifted_s);
    assign next_state_o = mixed_s ^ rkey_next_s;
    assign next_rkey_o  = rkey_next_s;

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, ready/valid on both sides.
// Optional abort input is built when AES_ABORT_EN is defined.
module aes128_iter_ctrl
    import aes128_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef AES_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_plaintext,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_ciphertext,
    output logic               busy
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes128_iter_ctrl: NR must be 10 for AES-128");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aes_fsm_e           fsm_q, fsm_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] rkey_q, rkey_d;
    logic [3:0]         round_q, round_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [BLOCK_W-1:0] core_state_s;
    logic [BLOCK_W-1:0] core_rkey_s;
    logic               last_round_s;
    logic               round_legal_s;
    logic               abort_hit_s;

`ifdef AES_ABORT_EN
    assign abort_hit_s = abort && (fsm_q != ST_IDLE);
`else
    assign abort_hit_s = 1'b0;
`endif

    assign last_round_s  = (round_q == LAST_ROUND);
    assign round_legal_s = (round_q >= 4'd1) && (round_q <= LAST_ROUND);

    aes128_round_core u_round_core (
        .state_i      (blk_q),
        .rkey_i       (rkey_q),
        .round_i      (round_q),
        .last_i       (last_round_s),
        .next_state_o (core_state_s),
        .next_rkey_o  (core_rkey_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            blk_q       <= 128'h0;
            rkey_q      <= 128'h0;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            rkey_q      <= rkey_d;
            round_q     <= round_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath update; abort outranks round completion and the handshake.
    always_comb begin
        fsm_d   = fsm_q;
        blk_d   = blk_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        if (abort_hit_s) begin
            fsm_d   = ST_IDLE;
            round_d = 4'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        fsm_d   = ST_ROUND;
                        blk_d   = in_plaintext ^ in_key;
                        rkey_d  = in_key;
                        round_d = 4'd1;
                    end else begin
                        round_d = 4'd0;
                    end
                end
                ST_ROUND: begin
                    if (!round_legal_s) begin
                        fsm_d   = ST_IDLE;
                        round_d = 4'd0;
                    end else if (last_round_s) begin
                        fsm_d   = ST_DONE;
                        blk_d   = core_state_s;
                        rkey_d  = core_rkey_s;
                        round_d = 4'd0;
                    end else begin
                        blk_d   = core_state_s;
                        rkey_d  = core_rkey_s;
                        round_d = round_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_d = ST_IDLE;
                    end else begin
                        fsm_d = ST_DONE;
                    end
                end
                default: begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the flags come straight off flops.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (fsm_d)
            ST_IDLE:  in_ready_d = 1'b1;
            ST_ROUND: busy_d     = 1'b1;
            ST_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default:  in_ready_d = 1'b1;
        endcase
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign out_ciphertext = blk_q;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl: byte-level AES reference plus a job-phase model,
// compared every cycle, with FIPS-197 literals pinning the reference.
module tb_aes128_iter_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_pt = 128'h0;
    logic [127:0] in_key = 128'h0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_ct;
`ifdef AES_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    aes128_iter_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef AES_ABORT_EN
        .abort          (abort),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_plaintext   (in_pt),
        .in_key         (in_key),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ciphertext (out_ct),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference AES (byte arrays, computed S-box) ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b[7]) ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            xb  = 8'(x);
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s[16], t[16], rk[16], tmp[4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            tmp[0] = sbox_t[rk[13]] ^ rc;
            tmp[1] = sbox_t[rk[14]];
            tmp[2] = sbox_t[rk[15]];
            tmp[3] = sbox_t[rk[12]];
            for (int j = 0; j < 16; j++) rk[j] = rk[j] ^ ((j < 4) ? tmp[j] : rk[j-4]);
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                    s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- job-phase model: -1 idle, 0..9 rounds done, 10 result held ----------------
    int           m_cnt = -1;
    logic [127:0] m_ct  = 128'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = -1;
`ifdef AES_ABORT_EN
        end else if (m_cnt >= 0 && abort) begin
            m_cnt = -1;
`endif
        end else if (m_cnt < 0) begin
            if (in_valid) begin
                m_ct  = aes_ref(in_pt, in_key);
                m_cnt = 0;
            end
        end else if (m_cnt < 10) begin
            m_cnt = m_cnt + 1;
        end else if (out_ready) begin
            m_cnt = -1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", {127'h0, in_ready}, {127'h0, (m_cnt < 0)});
        chk("busy", {127'h0, busy}, {127'h0, (m_cnt >= 0)});
        chk("out_valid", {127'h0, out_valid}, {127'h0, (m_cnt == 10)});
        if (m_cnt == 10) chk("ciphertext", out_ct, m_ct);
    end

    // Observed accept edges, for the back-to-back spacing check.
    int cyc_obs = 0;
    int acc_q[$];
    always @(posedge clk) begin
        cyc_obs++;
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc_obs);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [127:0] p, input logic [127:0] k);
        in_valid = 1'b1;
        in_pt    = p;
        in_key   = k;
        tick();
        in_valid = 1'b0;
        in_pt    = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_ov(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int lat;

    initial begin
        build_sbox();
        chk("model_sbox_00", {120'h0, sbox_t[0]}, {120'h0, 8'h63});
        chk("model_sbox_53", {120'h0, sbox_t[8'h53]}, {120'h0, 8'hed});
        chk("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
        chk("model_b", aes_ref(B_PT, B_KEY), B_CT);

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_ct", out_ct, 128'h0);
        rst_n = 1'b1;
        tick();

        // C.1 vector with latency
        start_job(C1_PT, C1_KEY);
        wait_ov(lat);
        chk("c1_latency", 128'(lat), 128'd10);
        chk("c1_ct", out_ct, C1_CT);
        out_ready = 1'b1;
        tick();
        chk("c1_idle", {126'h0, in_ready, out_valid}, 128'h2);
        out_ready = 1'b0;

        // B vector with 20 cycles of backpressure and ignored in_valid pulses
        start_job(B_PT, B_KEY);
        wait_ov(lat);
        chk("b_latency", 128'(lat), 128'd10);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            in_pt    = ~B_PT;
            tick();
            chk("bp_ct", out_ct, B_CT);
            chk("bp_flags", {126'h0, in_ready, out_valid}, 128'h1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release", {125'h0, in_ready, out_valid, busy}, 128'h4);
        out_ready = 1'b0;

        // Reset in the middle of round 5, then rerun C.1
        start_job(C1_PT, C1_KEY);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {125'h0, in_ready, out_valid, busy}, 128'h4);
        chk("midrst_ct", out_ct, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start_job(C1_PT, C1_KEY);
        wait_ov(lat);
        chk("rerun_latency", 128'(lat), 128'd10);
        chk("rerun_ct", out_ct, C1_CT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with in_valid held, inputs scrambled during the first job's rounds
        in_valid  = 1'b1;
        in_pt     = C1_PT;
        in_key    = C1_KEY;
        out_ready = 1'b1;
        tick();
        in_pt  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        in_key = 128'hffffffff_00000000_ffffffff_00000000;
        repeat (5) tick();
        in_pt  = B_PT;
        in_key = B_KEY;
        wait_ov(lat);
        chk("b2b_first_ct", out_ct, C1_CT);
        tick();
        chk("b2b_idle", {127'h0, in_ready}, 128'h1);
        tick();
        in_valid = 1'b0;
        wait_ov(lat);
        chk("b2b_second_lat", 128'(lat), 128'd10);
        chk("b2b_second_ct", out_ct, B_CT);
        tick();
        out_ready = 1'b0;
        if (acc_q.size() >= 2) begin
            chk("b2b_gap", 128'(acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2]), 128'd12);
        end else begin
            chk("b2b_accepts", 128'(acc_q.size()), 128'd2);
        end

`ifdef AES_ABORT_EN
        // Abort at round 3
        start_job(C1_PT, C1_KEY);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_r3", {125'h0, in_ready, out_valid, busy}, 128'h4);
        repeat (12) tick();
        // Abort is ignored in IDLE, then wins over the DONE handshake
        abort    = 1'b1;
        in_valid = 1'b1;
        in_pt    = C1_PT;
        in_key   = C1_KEY;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_busy", {127'h0, busy}, 128'h1);
        wait_ov(lat);
        chk("abort_job_ct", out_ct, C1_CT);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_done", {125'h0, in_ready, out_valid, busy}, 128'h4);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes128_iter_ctrl.md
AES128_ITER_CTRL -- requirements
Module: aes128_iter_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10: AES-128 round count; only 10 is legal, and elaboration SHALL fail on any other value.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1: plaintext/key offer.
REQ-005 SHALL have port in_ready  output  1: block accepts a new offer.
REQ-006 SHALL have port in_plaintext  input  128: plaintext, bit 127 = byte 0.
REQ-007 SHALL have port in_key  input  128: cipher key, bit 127 = byte 0.
REQ-008 SHALL have port out_valid  output  1: ciphertext available.
REQ-009 SHALL have port out_ready  input  1: consumer accepts the ciphertext.
REQ-010 SHALL have port out_ciphertext  output  128: result, same byte order as the inputs.
REQ-011 SHALL have port busy  output  1: high in ROUND and DONE states.
REQ-012 SHALL have port abort  input  1: present only under AES_ABORT_EN.

Function
REQ-013 SHALL implement the FSM states IDLE, ROUND and DONE.
REQ-014 in_ready SHALL be high only in IDLE; in_valid&&in_ready at edge E0 is the accept event.
REQ-015 On accept, the block SHALL register state = in_plaintext ^ in_key, rkey = in_key, round = 1, and move to ROUND.
REQ-016 In ROUND, each edge SHALL compute rkey_next = KeyExpansionRound(round, rkey) and apply it as follows.
- rounds 1-9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rkey_next.
- round 10: no MixColumns.
REQ-017 Each ROUND edge SHALL also update rkey <= rkey_next and round <= round+1.
REQ-018 After the round-10 edge (E10), the FSM SHALL enter DONE with out_valid=1; latency from accept edge E0 to out_valid high is exactly 10 edges.
REQ-019 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 in byte 0 of the word.
REQ-020 In DONE, out_valid and out_ciphertext SHALL remain stable until out_valid&&out_ready; at that edge the FSM returns to IDLE.
REQ-021 in_ready SHALL be low in DONE, so there is no overlap between jobs; back-to-back throughput is one block per 12 edges with out_ready held high.
REQ-022 in_valid, in_plaintext and in_key SHALL be ignored outside IDLE; they are sampled only at the accept edge.
REQ-023 out_ciphertext SHALL equal the state register; its value outside DONE is don't-care but SHALL be deterministic.
REQ-024 The round counter SHALL be 4 bits and SHALL never exceed 10.
- Any other round value in ROUND SHALL force a return to IDLE.

Reset
REQ-025 rst_n low SHALL asynchronously force the following, including mid-operation with no partial output.
- FSM = IDLE, round = 0, state = 0, rkey = 0.
- out_valid = 0, busy = 0.
REQ-026 in_ready SHALL be 1 during and after reset.

Configuration
REQ-027 The macro AES_ABORT_EN SHALL control the abort feature.
- Defined: the abort port exists; abort=1 at any edge in ROUND or DONE SHALL return to IDLE with out_valid=0 and discard the job. Abort has priority over round completion and over the output handshake in the same cycle. Abort SHALL have no effect in IDLE.
- Undefined: there is no abort port, and the behaviour is as REQ-013..REQ-024.

Structure
REQ-028 A shared package aes128_pkg SHALL hold the following.
- FSM state enum.
- NR constant.
- Rcon table.
- Width constants: block 128, word 32.
REQ-029 The one sub-module SHALL be aes128_round_core.
- It is combinational: state, rkey, round and last-round flag in; next state and next rkey out.
- It is built from the existing sbox, ShiftRows, MixColumns, AddRoundKey and KeyExpansionRound blocks.
REQ-030 The controller SHALL hold only the FSM, the counter and the state/rkey registers, and SHALL instantiate exactly one aes128_round_core.

Verification
REQ-031 FIPS-197 C.1 test: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 edges after accept.
REQ-032 FIPS-197 B test: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
REQ-033 Backpressure test: hold out_ready=0 for 20 cycles after out_valid.
- Required: ciphertext stable, in_ready=0, in_valid pulses ignored.
- Then out_ready=1 -> IDLE next edge.
REQ-034 Reset-mid-operation test: assert rst_n=0 at round 5, then re-run the C.1 vector.
- Required: out_valid never pulses during reset; the post-reset result is correct.
REQ-035 Back-to-back test: run C.1 then B with in_valid held and out_ready=1.
- Required: both results correct; accepts 12 edges apart; inputs changed during ROUND are not used.
REQ-036 With AES_ABORT_EN: abort at round 3 -> IDLE next edge, no out_valid; abort coincident with the DONE handshake -> no transfer counted.
